conv_output_stream: RTL and testbench

Parametrised output stage for the conv layers. It accepts NUM_CH packed channel results per input beat and buffers them in a DEPTH-entry FIFO. It serialises them into one OUT_WIDTH word per output beat under a registered valid/ready handshake. It counts FRAME_LEN output words and pulses `done` once per frame. It sits between a conv core's accumulator/result path and the next layer or the DMA writer.

---
 rtl/conv_out_pkg.sv | 32 +++
 rtl/conv_out_fifo.sv | 59 +++++
 rtl/conv_output_stream.sv | 163 ++++++++++++++++
 tb/tb_conv_output_stream.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_out_pkg.sv
// Shared types and helpers for the conv layer output stream: FSM state encoding,
// counter/index width helpers and the ReLU clamp applied to output words.
package conv_out_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Widest lane word the ReLU clamp can handle.
  localparam int RELU_W = 64;

  // Bits needed to hold the values 0..n (counters and occupancy levels).
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to index n items (never less than one bit).
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Treats the low 'width' bits of w as a two's-complement word and returns 0 if it is negative.
  function automatic logic [RELU_W-1:0] relu_clamp(input logic [RELU_W-1:0] w, input int width);
    logic [RELU_W-1:0] sign_mask;
    sign_mask = RELU_W'(1) << (width - 1);
    if ((w & sign_mask) != '0) return '0;
    return w;
  endfunction

endpackage

// File: rtl/conv_out_fifo.sv
// Synchronous DEPTH-entry FIFO with flush. The head entry is presented combinationally on o_data.
module conv_out_fifo
  import conv_out_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_push,
  input  logic [WIDTH-1:0]          i_data,
  input  logic                      i_pop,
  input  logic                      i_flush,
  output logic [WIDTH-1:0]          o_data,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [cnt_w(DEPTH)-1:0]   o_level
);

  localparam int PTR_W = idx_w(DEPTH);
  localparam int LVL_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign o_data    = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_level <= r_level + 1'b1;
      else if (w_do_pop && !w_do_push) r_level <= r_level - 1'b1;
    end
  end

endmodule

// File: rtl/conv_output_stream.sv
// Conv layer output stage: buffers NUM_CH-lane result beats and serialises them into FRAME_LEN-word frames.
// Optional build macro CONV_OUT_RELU_EN clamps negative lane words to zero as they enter the output register.
module conv_output_stream
  import conv_out_pkg::*;
#(
  parameter int OUT_WIDTH = 32,
  parameter int NUM_CH    = 4,
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          valid_in,
  output logic                          ready_out,
  input  logic [NUM_CH*OUT_WIDTH-1:0]   data_in,
  output logic                          valid_out,
  input  logic                          ready_in,
  output logic [OUT_WIDTH-1:0]          data_out,
  output logic                          done,
  output logic                          busy,
  output logic [cnt_w(DEPTH)-1:0]       fifo_level
);

  localparam int BEAT_W = NUM_CH * OUT_WIDTH;
  localparam int CNT_W  = cnt_w(FRAME_LEN);
  localparam int LANE_W = idx_w(NUM_CH);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(FRAME_LEN - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_CH - 1);

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_word_cnt;
  logic [LANE_W-1:0]     r_lane;
  logic                  r_valid_out;
  logic [OUT_WIDTH-1:0]  r_data_out;
  logic                  r_done;
  logic                  r_busy;

  logic                  w_run;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_flush;
  logic                  w_hs;
  logic                  w_last_hs;
  logic                  w_last_lane;
  logic                  w_load;
  logic [BEAT_W-1:0]     w_head;
  logic [OUT_WIDTH-1:0]  w_lanes [NUM_CH];
  logic [OUT_WIDTH-1:0]  w_lane;
  logic [OUT_WIDTH-1:0]  w_load_data;

  conv_out_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (data_in),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  assign w_run       = (r_state == ST_RUN);
  assign ready_out   = w_run && !w_full;
  assign w_push      = valid_in && ready_out;
  assign w_hs        = r_valid_out && ready_in;
  assign w_last_hs   = w_run && w_hs && (r_word_cnt == LAST_WORD);
  assign w_last_lane = (r_lane == LAST_LANE);

  // No new word is loaded on the frame's final handshake or while aborting;
  // leftover lanes of the head entry are discarded by the flush.
  assign w_load  = w_run && start && !w_last_hs && !w_empty && (!r_valid_out || ready_in);
  assign w_pop   = w_load && w_last_lane;
  assign w_flush = (w_run && (w_next != ST_RUN)) || (r_state == ST_DONE);

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      w_lanes[k] = w_head[k*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  assign w_lane = w_lanes[r_lane];

`ifdef CONV_OUT_RELU_EN
  logic [RELU_W-1:0] w_lane_ext;

  always_comb begin
    w_lane_ext                = '0;
    w_lane_ext[OUT_WIDTH-1:0] = w_lane;
  end

  assign w_load_data = OUT_WIDTH'(relu_clamp(w_lane_ext, OUT_WIDTH));
`else
  assign w_load_data = w_lane;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_next = ST_RUN;
      ST_RUN: begin
        if (!start)         w_next = ST_IDLE;
        else if (w_last_hs) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Word counter and lane index restart from zero on every entry into RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt <= '0;
      r_lane     <= '0;
    end else if (r_state == ST_IDLE) begin
      r_word_cnt <= '0;
      r_lane     <= '0;
    end else if (w_run) begin
      if (w_hs) r_word_cnt <= r_word_cnt + 1'b1;
      if (w_flush)     r_lane <= '0;
      else if (w_load) r_lane <= w_last_lane ? '0 : r_lane + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_done <= (w_next == ST_DONE);
      r_busy <= (w_next == ST_RUN);
      if (!w_run || (w_next != ST_RUN)) begin
        r_valid_out <= 1'b0;
      end else if (w_load) begin
        r_valid_out <= 1'b1;
        r_data_out  <= w_load_data;
      end else if (w_hs) begin
        r_valid_out <= 1'b0;
      end
    end
  end

  assign valid_out = r_valid_out;
  assign data_out  = r_data_out;
  assign done      = r_done;
  assign busy      = r_busy;

endmodule

// File: tb/tb_conv_output_stream.sv
// Bench for conv_output_stream: instance A runs 8-word frames, instance B runs 6-word frames.
module tb_conv_output_stream;

  localparam int OW    = 32;
  localparam int NC    = 4;
  localparam int DP    = 8;
  localparam int LVL_W = $clog2(DP + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             a_start = 1'b0, a_valid_in = 1'b0, a_ready_in = 1'b0;
  logic [NC*OW-1:0] a_data_in = '0;
  logic             a_ready_out, a_valid_out, a_done, a_busy;
  logic [OW-1:0]    a_data_out;
  logic [LVL_W-1:0] a_level;

  logic             b_start = 1'b0, b_valid_in = 1'b0, b_ready_in = 1'b0;
  logic [NC*OW-1:0] b_data_in = '0;
  logic             b_ready_out, b_valid_out, b_done, b_busy;
  logic [OW-1:0]    b_data_out;
  logic [LVL_W-1:0] b_level;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [OW-1:0] exp_q [$];

  conv_output_stream #(.OUT_WIDTH(OW), .NUM_CH(NC), .DEPTH(DP), .FRAME_LEN(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .valid_in(a_valid_in), .ready_out(a_ready_out),
    .data_in(a_data_in), .valid_out(a_valid_out), .ready_in(a_ready_in), .data_out(a_data_out),
    .done(a_done), .busy(a_busy), .fifo_level(a_level)
  );

  conv_output_stream #(.OUT_WIDTH(OW), .NUM_CH(NC), .DEPTH(DP), .FRAME_LEN(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .valid_in(b_valid_in), .ready_out(b_ready_out),
    .data_in(b_data_in), .valid_out(b_valid_out), .ready_in(b_ready_in), .data_out(b_data_out),
    .done(b_done), .busy(b_busy), .fifo_level(b_level)
  );

  function automatic logic [OW-1:0] relu_model(input logic [OW-1:0] v);
`ifdef CONV_OUT_RELU_EN
    return v[OW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({a_ready_out, a_valid_out, a_done, a_busy, a_level, a_data_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_a: got rdy=%b vld=%b done=%b busy=%b lvl=%0d data=%h want all 0",
               a_ready_out, a_valid_out, a_done, a_busy, a_level, a_data_out);
    end
    n_checks++;
    if ({b_ready_out, b_valid_out, b_done, b_busy, b_level, b_data_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: got rdy=%b vld=%b done=%b busy=%b lvl=%0d data=%h want all 0",
               b_ready_out, b_valid_out, b_done, b_busy, b_level, b_data_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Two beats of lanes 0..7, ready_in high: eight consecutive words, latency 2, one done pulse.
  task automatic test_basic();
    int words = 0, dones = 0, gaps = 0, beat = 0, acc_c = -1, first_c = -1;
    logic [OW-1:0] exp;
    a_ready_in = 1'b1;
    a_start    = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 30; c++) begin
      if (a_valid_out && a_ready_in) begin
        if (first_c < 0) first_c = c;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL basic_extra_word: got %h want no word", a_data_out);
        end else begin
          exp = exp_q.pop_front();
          if (a_data_out !== exp) begin
            n_fail++; $display("FAIL basic_word%0d: got %h want %h", words, a_data_out, exp);
          end
        end
        words++;
      end else if (words > 0 && words < 8) gaps++;
      if (a_done) begin dones++; a_start = 1'b0; end
      if (beat < 2 && a_ready_out && a_start) begin
        a_valid_in = 1'b1;
        a_data_in  = {OW'(beat*4+3), OW'(beat*4+2), OW'(beat*4+1), OW'(beat*4)};
        for (int k = 0; k < 4; k++) exp_q.push_back(OW'(beat*4+k));
        if (beat == 0) acc_c = c;
        beat++;
      end else a_valid_in = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (words != 8) begin n_fail++; $display("FAIL basic_count: got %0d want 8", words); end
    n_checks++;
    if (first_c - acc_c != 2) begin n_fail++; $display("FAIL basic_latency: got %0d want 2", first_c - acc_c); end
    n_checks++;
    if (gaps != 0) begin n_fail++; $display("FAIL basic_bubbles: got %0d want 0", gaps); end
    n_checks++;
    if (dones != 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses want 1", dones); end
    n_checks++;
    if (a_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b want 0", a_busy); end
    exp_q.delete();
  endtask

  // ready_in low for 20 cycles with valid_in held: FIFO fills, output frozen, then drains intact.
  task automatic test_backpressure();
    int acc = 0, frozen_bad = 0, seen_valid = 0, words = 0, dones = 0;
    logic [OW-1:0] exp;
    a_ready_in = 1'b0;
    a_start    = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      if (a_valid_out) begin
        seen_valid++;
        if (a_data_out !== OW'(100)) frozen_bad++;
      end
      a_valid_in = 1'b1;
      a_data_in  = {OW'(100+acc*4+3), OW'(100+acc*4+2), OW'(100+acc*4+1), OW'(100+acc*4)};
      if (a_ready_out) begin
        if (acc < 2) for (int k = 0; k < 4; k++) exp_q.push_back(OW'(100+acc*4+k));
        acc++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (acc != 8) begin n_fail++; $display("FAIL bp_accepted: got %0d want 8", acc); end
    n_checks++;
    if (a_ready_out !== 1'b0) begin n_fail++; $display("FAIL bp_ready_out: got %b want 0", a_ready_out); end
    n_checks++;
    if (a_level !== LVL_W'(8)) begin n_fail++; $display("FAIL bp_level: got %0d want 8", a_level); end
    n_checks++;
    if (seen_valid == 0 || frozen_bad != 0) begin
      n_fail++; $display("FAIL bp_frozen: got %0d valid cycles, %0d changed want >0, 0", seen_valid, frozen_bad);
    end
    a_valid_in = 1'b0;
    a_ready_in = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (a_valid_out && a_ready_in) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL bp_extra_word: got %h want no word", a_data_out);
        end else begin
          exp = exp_q.pop_front();
          if (a_data_out !== exp) begin
            n_fail++; $display("FAIL bp_word%0d: got %h want %h", words, a_data_out, exp);
          end
        end
        words++;
      end
      if (a_done) begin dones++; a_start = 1'b0; end
      @(negedge clk);
    end
    n_checks++;
    if (words != 8 || dones != 1) begin
      n_fail++; $display("FAIL bp_drain: got %0d words %0d dones want 8 1", words, dones);
    end
    n_checks++;
    if (a_level !== '0) begin n_fail++; $display("FAIL bp_flush: got level %0d want 0", a_level); end
    exp_q.delete();
  endtask

  // FRAME_LEN=6 with two beats: lanes 6 and 7 of the second beat are dropped.
  task automatic test_frame6();
    int words = 0, dones = 0, beat = 0;
    logic [OW-1:0] exp;
    b_ready_in = 1'b1;
    b_start    = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 30; c++) begin
      if (b_valid_out && b_ready_in) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL f6_extra_word: got %h want no word", b_data_out);
        end else begin
          exp = exp_q.pop_front();
          if (b_data_out !== exp) begin
            n_fail++; $display("FAIL f6_word%0d: got %h want %h", words, b_data_out, exp);
          end
        end
        words++;
      end
      if (b_done) begin dones++; b_start = 1'b0; end
      if (beat < 2 && b_ready_out && b_start) begin
        b_valid_in = 1'b1;
        b_data_in  = {OW'(200+beat*4+3), OW'(200+beat*4+2), OW'(200+beat*4+1), OW'(200+beat*4)};
        for (int k = 0; k < 4; k++) if (beat*4 + k < 6) exp_q.push_back(OW'(200+beat*4+k));
        beat++;
      end else b_valid_in = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (words != 6) begin n_fail++; $display("FAIL f6_count: got %0d want 6", words); end
    n_checks++;
    if (dones != 1) begin n_fail++; $display("FAIL f6_done: got %0d pulses want 1", dones); end
    n_checks++;
    if (b_level !== '0 || b_valid_out !== 1'b0) begin
      n_fail++; $display("FAIL f6_idle: got level %0d valid %b want 0 0", b_level, b_valid_out);
    end
    exp_q.delete();
  endtask

  // start dropped after three words aborts the frame; a restart counts a full frame from zero.
  task automatic test_abort_restart();
    int words = 0, dones = 0, beat = 0, words_at_done = -1;
    logic [OW-1:0] exp;
    a_ready_in = 1'b1;
    a_start    = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 20 && words < 3; c++) begin
      if (a_valid_out && a_ready_in) begin
        n_checks++;
        exp = exp_q.size() ? exp_q.pop_front() : 'x;
        if (a_data_out !== exp) begin
          n_fail++; $display("FAIL abort_word%0d: got %h want %h", words, a_data_out, exp);
        end
        words++;
      end
      if (words == 3) begin
        a_start    = 1'b0;
        a_valid_in = 1'b0;
      end else if (beat < 2 && a_ready_out) begin
        a_valid_in = 1'b1;
        a_data_in  = {OW'(300+beat*4+3), OW'(300+beat*4+2), OW'(300+beat*4+1), OW'(300+beat*4)};
        for (int k = 0; k < 4; k++) exp_q.push_back(OW'(300+beat*4+k));
        beat++;
      end else a_valid_in = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if ({a_busy, a_valid_out, a_done, a_level} !== '0) begin
      n_fail++; $display("FAIL abort_idle: got busy=%b vld=%b done=%b lvl=%0d want all 0",
                         a_busy, a_valid_out, a_done, a_level);
    end
    for (int c = 0; c < 3; c++) begin
      if (a_done) dones++;
      @(negedge clk);
    end
    n_checks++;
    if (dones != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", dones); end
    exp_q.delete();
    words = 0; beat = 0;
    a_start = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 30; c++) begin
      if (a_valid_out && a_ready_in) begin
        n_checks++;
        exp = exp_q.size() ? exp_q.pop_front() : 'x;
        if (a_data_out !== exp) begin
          n_fail++; $display("FAIL restart_word%0d: got %h want %h", words, a_data_out, exp);
        end
        words++;
      end
      if (a_done) begin dones++; words_at_done = words; a_start = 1'b0; end
      if (beat < 2 && a_ready_out && a_start) begin
        a_valid_in = 1'b1;
        a_data_in  = {OW'(400+beat*4+3), OW'(400+beat*4+2), OW'(400+beat*4+1), OW'(400+beat*4)};
        for (int k = 0; k < 4; k++) exp_q.push_back(OW'(400+beat*4+k));
        beat++;
      end else a_valid_in = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (dones != 1 || words_at_done != 8) begin
      n_fail++; $display("FAIL restart_count: got %0d dones at word %0d want 1 at 8", dones, words_at_done);
    end
    exp_q.delete();
  endtask

  // Signed lane values, including -5 and 7 in lanes 0 and 1.
  task automatic test_relu();
    int words = 0, beat = 0;
    logic [OW-1:0] exp;
    logic [OW-1:0] vals [8];
    vals[0] = -OW'(5);          vals[1] = OW'(7);
    vals[2] = '1;               vals[3] = '0;
    vals[4] = 32'h8000_0000;    vals[5] = 32'h7FFF_FFFF;
    vals[6] = OW'(5);           vals[7] = -OW'(100);
    a_ready_in = 1'b1;
    a_start    = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 30; c++) begin
      if (a_valid_out && a_ready_in) begin
        n_checks++;
        exp = exp_q.size() ? exp_q.pop_front() : 'x;
        if (a_data_out !== exp) begin
          n_fail++; $display("FAIL relu_word%0d: got %h want %h", words, a_data_out, exp);
        end
        words++;
      end
      if (a_done) a_start = 1'b0;
      if (beat < 2 && a_ready_out && a_start) begin
        a_valid_in = 1'b1;
        a_data_in  = {vals[beat*4+3], vals[beat*4+2], vals[beat*4+1], vals[beat*4]};
        for (int k = 0; k < 4; k++) exp_q.push_back(relu_model(vals[beat*4+k]));
        beat++;
      end else a_valid_in = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (words != 8) begin n_fail++; $display("FAIL relu_count: got %0d want 8", words); end
    exp_q.delete();
  endtask

  // Asynchronous reset with the FIFO half full clears everything immediately.
  task automatic test_reset_mid();
    int acc = 0, stray = 0;
    a_ready_in = 1'b0;
    a_start    = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 10 && acc < 4; c++) begin
      a_valid_in = 1'b1;
      a_data_in  = {OW'(503+acc*4), OW'(502+acc*4), OW'(501+acc*4), OW'(500+acc*4)};
      if (a_ready_out) acc++;
      @(negedge clk);
    end
    a_valid_in = 1'b0;
    n_checks++;
    if (a_level !== LVL_W'(4)) begin n_fail++; $display("FAIL rstmid_level: got %0d want 4", a_level); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_ready_out, a_valid_out, a_done, a_busy, a_level, a_data_out} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got rdy=%b vld=%b done=%b busy=%b lvl=%0d data=%h want all 0",
               a_ready_out, a_valid_out, a_done, a_busy, a_level, a_data_out);
    end
    a_start    = 1'b0;
    a_ready_in = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (a_valid_out || a_ready_out || a_busy) stray++;
    end
    n_checks++;
    if (stray != 0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", stray); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_frame6();
    test_abort_restart();
    test_relu();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
